code_phase_search: RTL
======================

Name: code_phase_search

Overview:
- Closed-loop acquisition controller placed directly downstream of the 128-tap correlator bank.
- Consumes the per-dump winner (max_ID, accum_max) on every accumulation flag (CLK_10k).
- Averages N_AVG dumps, decides lock or no-lock, and steps the correlator phase input to slide the 32-chip search window over 1023 chips.
- Holds lock while the peak stays strong and positionally stable.

Parameters:
- N_AVG, 4: dumps averaged per decision; power of two, 2..16.
- THRESH, 5000: lock threshold on averaged |max_sum|, unsigned 32-bit.
- PHASE_STEP, 32: chips added to phase per failed window, 1..1022.
- ID_TOL, 2: max |max_id − reference id| for a dump to count as consistent.
- SETTLE_DUMPS, 1: dumps discarded after any phase change or unlock, 0..7.
- LOCK_MISS, 3: consecutive bad dumps that drop lock, 1..15.

Ports:
- CLK_16M  in  1  system clock.
- RST  in  1  asynchronous active-high reset.
- restart  in  1  one-cycle pulse that restarts the search from phase 0.
- dump_flag  in  1  accumulation flag (CLK_10k level); its rising edge is a dump event.
- max_id  in  8  index of the winning correlator for the current dump.
- max_sum  in  32  signed accumulator of the winner.
- phase  out  10  code phase driven to the correlators, 0..1022.
- locked  out  1  lock indicator.
- lock_id  out  8  reference correlator index while locked.
- avg_sum  out  32  last computed average of |max_sum|.
- search_wrap  out  1  one-cycle pulse when phase wraps past 1022.

Behaviour:
- Reset (async, RST=1): phase=0, locked=0, lock_id=0, avg_sum=0, search_wrap=0, state=SETTLE, all counters and accumulators 0, dump_flag history register 0.
- Event detection: dump_flag registered into d1; dump event = dump_flag & ~d1. All updates occur on the clock edge ending the event cycle, so outputs are visible 1 cycle after dump_flag is sampled high.
- Absolute value: |max_sum|, with −2^31 saturated to 2^31−1. Accumulator is 36 bits, unsigned. avg = acc >> log2(N_AVG), truncated to 32 bits.
- ID distance: |max_id − ref| computed as unsigned 8-bit absolute difference, no wrap.
- SETTLE state:
  - Counts dump events and ignores their data.
  - After SETTLE_DUMPS events, goes to ACC with acc=0 and cnt=0.
  - If SETTLE_DUMPS=0, goes to ACC on the next cycle with no event required.
- ACC state:
  - First event latches ref=max_id.
  - Every event adds |max_sum| to acc. A consistency flag is cleared if any dump's ID distance exceeds ID_TOL.
  - On the N_AVG-th event: avg_sum = avg.
  - If avg ≥ THRESH and consistent: locked=1, lock_id=ref, state=TRACK, miss=0; phase unchanged.
  - Otherwise: next = phase + PHASE_STEP. If next ≥ 1023, phase = next − 1023 and search_wrap=1 for exactly that cycle; else phase = next. State returns to SETTLE.
- TRACK state, on each event:
  - Good dump (|max_sum| ≥ THRESH and distance(max_id, lock_id) ≤ ID_TOL): miss=0.
  - Bad dump: miss+1.
  - When miss reaches LOCK_MISS: locked=0, lock_id retained, state=SETTLE, phase unchanged.
  - lock_id does not track drift.
- restart: highest priority below RST.
  - Effect: phase=0, locked=0, state=SETTLE, counters cleared, avg_sum retained.
  - A dump event in the same cycle is discarded.
  - The dump_flag history register still updates, so a level already high is not a new event.
- Held-high dump_flag produces exactly one event.
- Back-to-back events are legal (dump_flag toggling every 2 cycles).

Test Plan:
- Search step: max_sum=1000 on every dump, max_id=10. Phase stays 0 for 5 events, becomes 32 one cycle after the 5th; avg_sum=1000, locked=0.
- Wrap: continue with max_sum=1000 until phase=992. The next failed window gives phase=1, with search_wrap high for exactly 1 cycle.
- Lock: after settle, 4 dumps of max_sum=6000 with ids 40,41,40,38. Result: locked=1, lock_id=40, avg_sum=6000, phase unchanged. Then max_sum=−8000 at id 41 keeps lock.
- Inconsistent ID: dumps 6000 with ids 40,40,45,40 → locked=0, phase += 32.
- Loss of lock: while locked, give 2 bad dumps, 1 good, then 3 bad (max_sum=100). locked falls only on the 6th dump; phase unchanged; the FSM re-settles and re-averages.
- Restart and reset: assert restart coincident with a dump edge at phase=64 → phase=0 next cycle and the event is ignored. Assert RST mid-ACC → all outputs reach reset values asynchronously.

Source files
------------

// File: rtl/code_phase_search.sv
// code_phase_search: acquisition controller behind the correlator bank.
// It averages N_AVG dump winners and either declares lock or slides the code
// phase by PHASE_STEP chips modulo 1023. While locked, it tracks consecutive
// bad dumps and drops lock after LOCK_MISS of them.
module code_phase_search #(
  parameter int          N_AVG        = 4,
  parameter logic [31:0] THRESH       = 32'd5000,
  parameter int          PHASE_STEP   = 32,
  parameter int          ID_TOL       = 2,
  parameter int          SETTLE_DUMPS = 1,
  parameter int          LOCK_MISS    = 3
) (
  input  logic        CLK_16M,
  input  logic        RST,
  input  logic        restart,
  input  logic        dump_flag,
  input  logic [7:0]  max_id,
  input  logic [31:0] max_sum,
  output logic [9:0]  phase,
  output logic        locked,
  output logic [7:0]  lock_id,
  output logic [31:0] avg_sum,
  output logic        search_wrap
);

  localparam int          SHIFT     = $clog2(N_AVG);
  localparam logic [4:0]  AVG_N     = 5'(N_AVG);
  localparam logic [3:0]  SETTLE_N  = 4'(SETTLE_DUMPS);
  localparam logic [3:0]  MISS_N    = 4'(LOCK_MISS);
  localparam logic [7:0]  TOL       = 8'(ID_TOL);
  localparam logic [10:0] STEP      = 11'(PHASE_STEP);
  localparam logic [10:0] PHASE_MOD = 11'd1023;

  typedef enum logic [1:0] {SETTLE, ACC, TRACK} state_t;

  state_t      state_reg, state_next;
  logic        d1_reg;
  logic [9:0]  phase_reg, phase_next;
  logic        locked_reg, locked_next;
  logic [7:0]  lock_id_reg, lock_id_next;
  logic [31:0] avg_sum_reg, avg_sum_next;
  logic        wrap_reg, wrap_next;
  logic [3:0]  settle_cnt_reg, settle_cnt_next;
  logic [4:0]  cnt_reg, cnt_next;
  logic [35:0] acc_reg, acc_next;
  logic [7:0]  ref_reg, ref_next;
  logic        consistent_reg, consistent_next;
  logic [3:0]  miss_reg, miss_next;

  logic        dump_event;
  logic [31:0] mag;
  logic [7:0]  ref_sel;
  logic        consistent_sel;
  logic [35:0] acc_sum;
  logic [31:0] avg_val;
  logic [10:0] phase_sum;
  logic        phase_wraps;
  logic [9:0]  phase_wrapped;
  logic        track_good;

  // Unsigned distance between two correlator indices; no modular wrap.
  function automatic logic [7:0] id_dist(input logic [7:0] a, input logic [7:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  assign dump_event = dump_flag & ~d1_reg;

  // Magnitude of the winner; the most negative value saturates to max positive.
  always_comb begin
    mag = max_sum;
    if (max_sum == 32'h8000_0000) begin
      mag = 32'h7FFF_FFFF;
    end else if (max_sum[31]) begin
      mag = -max_sum;
    end
  end

  // Window datapath: the first dump of a window seeds ref, acc and consistency.
  always_comb begin
    ref_sel        = (cnt_reg == 5'd0) ? max_id : ref_reg;
    consistent_sel = ((cnt_reg == 5'd0) || consistent_reg) && (id_dist(max_id, ref_sel) <= TOL);
    acc_sum        = ((cnt_reg == 5'd0) ? 36'd0 : acc_reg) + {4'd0, mag};
    avg_val        = acc_sum[SHIFT +: 32];
    phase_sum      = {1'b0, phase_reg} + STEP;
    phase_wraps    = (phase_sum >= PHASE_MOD);
    phase_wrapped  = phase_wraps ? 10'(phase_sum - PHASE_MOD) : phase_sum[9:0];
    track_good     = (mag >= THRESH) && (id_dist(max_id, lock_id_reg) <= TOL);
  end

  // Next-state and output decisions; restart overrides any dump in the same cycle.
  always_comb begin
    state_next      = state_reg;
    phase_next      = phase_reg;
    locked_next     = locked_reg;
    lock_id_next    = lock_id_reg;
    avg_sum_next    = avg_sum_reg;
    wrap_next       = 1'b0;
    settle_cnt_next = settle_cnt_reg;
    cnt_next        = cnt_reg;
    acc_next        = acc_reg;
    ref_next        = ref_reg;
    consistent_next = consistent_reg;
    miss_next       = miss_reg;

    if (restart) begin
      phase_next      = 10'd0;
      locked_next     = 1'b0;
      state_next      = SETTLE;
      settle_cnt_next = 4'd0;
      cnt_next        = 5'd0;
      acc_next        = 36'd0;
      ref_next        = 8'd0;
      consistent_next = 1'b1;
      miss_next       = 4'd0;
    end else begin
      case (state_reg)
        SETTLE: begin
          if (SETTLE_N == 4'd0) begin
            state_next = ACC;
            acc_next   = 36'd0;
            cnt_next   = 5'd0;
          end else if (dump_event) begin
            if (settle_cnt_reg + 4'd1 == SETTLE_N) begin
              state_next      = ACC;
              acc_next        = 36'd0;
              cnt_next        = 5'd0;
              settle_cnt_next = 4'd0;
            end else begin
              settle_cnt_next = settle_cnt_reg + 4'd1;
            end
          end
        end
        ACC: begin
          if (dump_event) begin
            cnt_next        = cnt_reg + 5'd1;
            acc_next        = acc_sum;
            ref_next        = ref_sel;
            consistent_next = consistent_sel;
            if (cnt_reg + 5'd1 == AVG_N) begin
              avg_sum_next = avg_val;
              if ((avg_val >= THRESH) && consistent_sel) begin
                locked_next  = 1'b1;
                lock_id_next = ref_sel;
                state_next   = TRACK;
                miss_next    = 4'd0;
              end else begin
                phase_next      = phase_wrapped;
                wrap_next       = phase_wraps;
                state_next      = SETTLE;
                settle_cnt_next = 4'd0;
              end
            end
          end
        end
        TRACK: begin
          if (dump_event) begin
            if (track_good) begin
              miss_next = 4'd0;
            end else if (miss_reg + 4'd1 == MISS_N) begin
              locked_next     = 1'b0;
              state_next      = SETTLE;
              settle_cnt_next = 4'd0;
              miss_next       = 4'd0;
            end else begin
              miss_next = miss_reg + 4'd1;
            end
          end
        end
        default: state_next = SETTLE;
      endcase
    end
  end

  // State and datapath registers; the dump_flag history updates even on restart.
  always_ff @(posedge CLK_16M or posedge RST) begin
    if (RST) begin
      state_reg      <= SETTLE;
      d1_reg         <= 1'b0;
      phase_reg      <= 10'd0;
      locked_reg     <= 1'b0;
      lock_id_reg    <= 8'd0;
      avg_sum_reg    <= 32'd0;
      wrap_reg       <= 1'b0;
      settle_cnt_reg <= 4'd0;
      cnt_reg        <= 5'd0;
      acc_reg        <= 36'd0;
      ref_reg        <= 8'd0;
      consistent_reg <= 1'b1;
      miss_reg       <= 4'd0;
    end else begin
      state_reg      <= state_next;
      d1_reg         <= dump_flag;
      phase_reg      <= phase_next;
      locked_reg     <= locked_next;
      lock_id_reg    <= lock_id_next;
      avg_sum_reg    <= avg_sum_next;
      wrap_reg       <= wrap_next;
      settle_cnt_reg <= settle_cnt_next;
      cnt_reg        <= cnt_next;
      acc_reg        <= acc_next;
      ref_reg        <= ref_next;
      consistent_reg <= consistent_next;
      miss_reg       <= miss_next;
    end
  end

  assign phase       = phase_reg;
  assign locked      = locked_reg;
  assign lock_id     = lock_id_reg;
  assign avg_sum     = avg_sum_reg;
  assign search_wrap = wrap_reg;

endmodule
